// File: rtl/pad_out_arb_pkg.sv
// Shared types and defaults for the output-pad arbiter.
// Optional grant timeout is enabled with `define PAD_OUT_ARB_TIMEOUT_EN.
package pad_out_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int       DEF_GAP_CYCLES = 2;
  localparam int       DEF_MAX_HOLD   = 8;
  localparam logic     DEF_IDLE_LEVEL = 1'b0;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((32'sd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pad_out_arbiter_rr_pick.sv
// Combinational round-robin selector: first request above index `last`, wrapping.
module rr_pick
  import pad_out_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  int   cand_s;
  logic found_s;

  // Scan N positions starting just above the previous owner.
  always_comb begin
    onehot  = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = 0;
    for (int i = 1; i <= N; i++) begin
      cand_s = (int'(last) + i) % N;
      if (!found_s && req[cand_s]) begin
        found_s        = 1'b1;
        onehot[cand_s] = 1'b1;
        idx            = IW'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/pad_out_arbiter.sv
// Shares one output pad between NUM_REQ requesters with an idle gap between owners.
// Optional forced release after MAX_HOLD cycles: `define PAD_OUT_ARB_TIMEOUT_EN.
module pad_out_arbiter
  import pad_out_arb_pkg::*;
#(
  parameter int   NUM_REQ    = 4,
  parameter int   GAP_CYCLES = DEF_GAP_CYCLES,
  parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL,
  parameter int   MAX_HOLD   = DEF_MAX_HOLD
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [NUM_REQ-1:0] DIN,
  output logic [NUM_REQ-1:0] GNT,
  output logic               PAD_I,
  output logic               BUSY,
  output logic               TIMEOUT
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int GW = idx_width(GAP_CYCLES);

  arb_state_t         state_r, state_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_s;
  logic               pad_r, pad_s;
  logic               busy_r;
  logic [IW-1:0]      last_r, last_s;
  logic [IW-1:0]      owner_r, owner_s;
  logic [GW-1:0]      gap_r, gap_s;
  logic               timeout_s;

  logic [NUM_REQ-1:0] win_onehot_s;
  logic [IW-1:0]      win_idx_s;
  logic               any_req_s;

`ifdef PAD_OUT_ARB_TIMEOUT_EN
  localparam int HW = idx_width(MAX_HOLD);
  logic [HW-1:0] hold_r, hold_s;
  logic          timeout_r;
`endif

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req     (REQ),
    .last    (last_r),
    .onehot  (win_onehot_s),
    .idx     (win_idx_s),
    .any_req (any_req_s)
  );

  // Next-state, grant, pad data and counter logic.
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    pad_s     = pad_r;
    last_s    = last_r;
    owner_s   = owner_r;
    gap_s     = gap_r;
    timeout_s = 1'b0;
`ifdef PAD_OUT_ARB_TIMEOUT_EN
    hold_s    = hold_r;
`endif
    case (state_r)
      IDLE: begin
        pad_s = IDLE_LEVEL;
        gnt_s = '0;
        if (any_req_s) begin
          gnt_s   = win_onehot_s;
          owner_s = win_idx_s;
          state_s = GRANT;
`ifdef PAD_OUT_ARB_TIMEOUT_EN
          hold_s  = '0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (!REQ[owner_r]) begin
          gnt_s   = '0;
          last_s  = owner_r;
          state_s = GAP;
          gap_s   = '0;
          pad_s   = IDLE_LEVEL;
`ifdef PAD_OUT_ARB_TIMEOUT_EN
        end else if (hold_r == HW'(MAX_HOLD - 1)) begin
          // Owner still requesting but out of budget: release and demote it.
          gnt_s     = '0;
          last_s    = owner_r;
          state_s   = GAP;
          gap_s     = '0;
          pad_s     = IDLE_LEVEL;
          timeout_s = 1'b1;
`endif
        end else begin
          pad_s = DIN[owner_r];
`ifdef PAD_OUT_ARB_TIMEOUT_EN
          hold_s = hold_r + HW'(1);
`endif
        end
      end
      GAP: begin
        pad_s = IDLE_LEVEL;
        gnt_s = '0;
        if (gap_r == GW'(GAP_CYCLES - 1)) begin
          state_s = IDLE;
          gap_s   = '0;
        end else begin
          gap_s = gap_r + GW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = '0;
        pad_s   = IDLE_LEVEL;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      gnt_r   <= '0;
      pad_r   <= IDLE_LEVEL;
      busy_r  <= 1'b0;
      last_r  <= IW'(NUM_REQ - 1);
      owner_r <= '0;
      gap_r   <= '0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      pad_r   <= pad_s;
      busy_r  <= (state_s != IDLE);
      last_r  <= last_s;
      owner_r <= owner_s;
      gap_r   <= gap_s;
    end
  end

`ifdef PAD_OUT_ARB_TIMEOUT_EN
  // Hold counter and timeout pulse register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_r    <= '0;
      timeout_r <= 1'b0;
    end else begin
      hold_r    <= hold_s;
      timeout_r <= timeout_s;
    end
  end

  assign TIMEOUT = timeout_r;
`else
  assign TIMEOUT = timeout_s;
`endif

  assign GNT   = gnt_r;
  assign PAD_I = pad_r;
  assign BUSY  = busy_r;

endmodule

// File: tb/tb_pad_out_arbiter.sv
// Directed bench for pad_out_arbiter (NUM_REQ=4, GAP_CYCLES=2, IDLE_LEVEL=0, MAX_HOLD=8).
module tb_pad_out_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic [3:0] DIN;
  logic [3:0] GNT;
  logic       PAD_I;
  logic       BUSY;
  logic       TIMEOUT;

  int errors = 0;
  int checks = 0;

  pad_out_arbiter #(
    .NUM_REQ(4), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0), .MAX_HOLD(8)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DIN(DIN),
    .GNT(GNT), .PAD_I(PAD_I), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1;
    REQ = 4'b1111;
    DIN = 4'b0000;

    // Reset with all requests pending
    tick();
    chk("rst_gnt", 8'(GNT), 8'h00);
    chk("rst_pad", 8'(PAD_I), 8'h00);
    chk("rst_busy", 8'(BUSY), 8'h00);
    chk("rst_timeout", 8'(TIMEOUT), 8'h00);
    RST = 1'b0;
    tick();
    chk("post_rst_gnt", 8'(GNT), 8'h01);
    chk("post_rst_busy", 8'(BUSY), 8'h01);
    REQ = 4'b0000;
    tick();
    chk("rel0_gnt", 8'(GNT), 8'h00);
    tick();
    tick();
    chk("rel0_idle_busy", 8'(BUSY), 8'h00);

    // Round robin between requesters 1 and 3
    REQ = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] exp_g;
      exp_g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      tick();
      chk("rr_gnt", 8'(GNT), 8'(exp_g));
      tick();
      tick();
      chk("rr_hold", 8'(GNT), 8'(exp_g));
      REQ = 4'b1010 & ~exp_g;
      tick();
      chk("rr_rel", 8'(GNT), 8'h00);
      REQ = 4'b1010;
      tick();
      chk("rr_gap", 8'(GNT), 8'h00);
      tick();
      chk("rr_idle_gnt", 8'(GNT), 8'h00);
      chk("rr_idle_busy", 8'(BUSY), 8'h00);
    end
    REQ = 4'b0000;
    tick();

    // Data path: owner 2, DIN[0] must never reach the pad
    REQ = 4'b0100;
    DIN = 4'b0001;
    tick();
    chk("dp_gnt", 8'(GNT), 8'h04);
    chk("dp_first_pad", 8'(PAD_I), 8'h00);
    DIN = 4'b0101;
    tick();
    chk("dp_pad1", 8'(PAD_I), 8'h01);
    DIN = 4'b0001;
    tick();
    chk("dp_pad0", 8'(PAD_I), 8'h00);
    DIN = 4'b0101;
    tick();
    chk("dp_pad1b", 8'(PAD_I), 8'h01);

    // Gap after release
    REQ = 4'b0000;
    tick();
    chk("gap1_pad", 8'(PAD_I), 8'h00);
    chk("gap1_busy", 8'(BUSY), 8'h01);
    chk("gap1_gnt", 8'(GNT), 8'h00);
    tick();
    chk("gap2_pad", 8'(PAD_I), 8'h00);
    chk("gap2_busy", 8'(BUSY), 8'h01);
    tick();
    chk("gap_end_busy", 8'(BUSY), 8'h00);
    chk("gap_end_pad", 8'(PAD_I), 8'h00);

    // Reset while requester 2 owns the pad
    REQ = 4'b0100;
    tick();
    chk("mid_gnt", 8'(GNT), 8'h04);
    RST = 1'b1;
    REQ = 4'b0101;
    tick();
    chk("mid_rst_gnt", 8'(GNT), 8'h00);
    chk("mid_rst_pad", 8'(PAD_I), 8'h00);
    chk("mid_rst_busy", 8'(BUSY), 8'h00);
    RST = 1'b0;
    tick();
    chk("mid_regrant", 8'(GNT), 8'h01);
    REQ = 4'b0000;
    tick();
    tick();
    tick();
    chk("mid_idle_busy", 8'(BUSY), 8'h00);

`ifdef PAD_OUT_ARB_TIMEOUT_EN
    // Forced release after 8 grant cycles
    REQ = 4'b0001;
    tick();
    chk("to_gnt0", 8'(GNT), 8'h01);
    repeat (3) tick();
    REQ = 4'b0011;
    repeat (4) tick();
    chk("to_hold8", 8'(GNT), 8'h01);
    chk("to_not_yet", 8'(TIMEOUT), 8'h00);
    tick();
    chk("to_pulse", 8'(TIMEOUT), 8'h01);
    chk("to_rel_gnt", 8'(GNT), 8'h00);
    tick();
    chk("to_pulse_end", 8'(TIMEOUT), 8'h00);
    chk("to_gap_busy", 8'(BUSY), 8'h01);
    tick();
    chk("to_idle_gnt", 8'(GNT), 8'h00);
    tick();
    chk("to_next_gnt", 8'(GNT), 8'h02);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
